msix_wr_gen: RTL and testbench
==============================

// Module: msix_wr_gen
// PURPOSE
//  MSI-X message generator feeding the host interface. Latches per-vector interrupt requests into
//  a pending-bit array, applies per-vector and function masks, and arbitrates unmasked pending
//  vectors round-robin. Emits one DW memory write per interrupt to the host write port, using the
//  vector's programmed address/data from an internal MSI-X table.
// PARAMETERS
//  NUM_VEC  8   number of MSI-X vectors (2..32)
//  ADDR_W   64  message address width
//  DATA_W   32  message data width (one DW)
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        synchronous active-high reset
//  tbl_we     in   1        table entry write strobe
//  tbl_idx    in   $clog2(NUM_VEC)  entry index for tbl_we
//  tbl_addr   in   ADDR_W   message address written to entry
//  tbl_data   in   DATA_W   message data written to entry
//  tbl_mask   in   1        per-vector mask bit written to entry
//  func_mask  in   1        function mask; 1 blocks all vectors
//  intr_req   in   NUM_VEC  per-vector request, 1-cycle pulse per event
//  wr_valid   out  1        write request valid
//  wr_addr    out  ADDR_W   write address, stable while wr_valid
//  wr_data    out  DATA_W   write data, stable while wr_valid
//  wr_ready   in   1        host accepts write when wr_valid&&wr_ready
//  pba        out  NUM_VEC  pending-bit array
//  busy       out  1        1 when state==SEND
// BEHAVIOUR
//  Reset: wr_valid=0, wr_addr=0, wr_data=0, pba=0, busy=0, state=IDLE, rr pointer=0;
//   all table entries addr=0, data=0, mask=1 (all vectors masked out of reset).
//  Table: tbl_we writes entry tbl_idx at the edge; new values used from the next cycle. Write to
//   the entry currently in SEND does not change the in-flight wr_addr/wr_data (captured at grant).
//  Pending: pba[i] set at the edge after intr_req[i]. Multiple requests on a pending vector
//   coalesce to one bit (one message). Masked vectors still set pba and stay pending.
//  Eligible = pba & ~vec_mask & {NUM_VEC{~func_mask}}.
//  FSM IDLE: if eligible!=0, grant first eligible index at or after rr pointer (wrapping
//   NUM_VEC-1 -> 0); capture table addr/data into wr_addr/wr_data; set wr_valid; -> SEND.
//   Rr pointer = grant+1 mod NUM_VEC. Else stay IDLE.
//  FSM SEND: hold wr_valid/wr_addr/wr_data stable. On wr_valid&&wr_ready: clear pba[grant],
//   drop wr_valid, -> IDLE. Masks changing during SEND do not retract the write.
//  Latency: intr_req pulse in cycle 0 (IDLE, unmasked) -> pba set cycle 1 -> wr_valid cycle 2.
//   Minimum one IDLE cycle between successive writes (back-to-back spacing 2 cycles with wr_ready=1).
//  Simultaneous: intr_req[g] in the handshake cycle of vector g -> pba[g] stays 1 (set wins);
//   vector sent again later. Requests on other vectors during SEND just set pba.
//  Unmask: clearing a vector or func mask with pba bit set makes it eligible next cycle.
//  Reset mid-SEND: wr_valid deasserts at that edge, in-flight write abandoned, pba cleared.
//  wr_addr passed through unmodified (no alignment forcing). No backpressure limit on wr_ready wait.
// TESTING
//  1 Program vec0 addr=0x1 data=0x12345678 mask=0, func_mask=0, pulse intr_req[0], wr_ready=1
//    -> wr_valid in cycle 2 with addr 0x1, data 0x12345678; pba=0 after handshake.
//  2 vec3 mask=1, pulse intr_req[3] -> pba[3]=1, no write; clear mask -> write in 1 cycle, pba[3]=0.
//  3 Vecs 1,2,5 unmasked, pulse all same cycle, wr_ready=1 -> writes in order 1,2,5, 2 cycles apart;
//    then pulse 1 and 5 -> order 5,1 is not allowed: rr pointer=6 so order is 1 then 5 (wrap).
//  4 wr_ready=0 for 10 cycles during SEND; rewrite that entry's data to 0xDEAD -> wr_addr/wr_data
//    unchanged throughout; func_mask=1 mid-SEND -> write still completes.
//  5 intr_req[2] pulsed in vec2 handshake cycle -> pba[2]=1 after, second write for vec2 follows.
//  6 Assert rst while wr_valid=1 -> next cycle wr_valid=0, pba=0, all masks=1; no write after.

Source files
------------

// File: rtl/msix_wr_if.sv
// Host write port of the MSI-X generator: one DW memory write per
// valid/ready handshake.
interface msix_wr_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/msix_wr_gen.sv
// MSI-X message generator: latches interrupt requests into a pending-bit array,
// applies vector/function masks and emits round-robin DW writes from the table.
module msix_wr_gen #(
  parameter  int NUM_VEC = 8,
  parameter  int ADDR_W  = 64,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = $clog2(NUM_VEC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_we_i,
  input  logic [IDX_W-1:0]   tbl_idx_i,
  input  logic [ADDR_W-1:0]  tbl_addr_i,
  input  logic [DATA_W-1:0]  tbl_data_i,
  input  logic               tbl_mask_i,
  input  logic               func_mask_i,
  input  logic [NUM_VEC-1:0] intr_req_i,
  msix_wr_if.master          wr,
  output logic [NUM_VEC-1:0] pba_o,
  output logic               busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [ADDR_W-1:0]  tblAddr_q [NUM_VEC];
  logic [DATA_W-1:0]  tblData_q [NUM_VEC];
  logic [NUM_VEC-1:0] vecMask_q;

  logic [0:0]         state_q,   state_d;
  logic [NUM_VEC-1:0] pba_q,     pba_d;
  logic [IDX_W-1:0]   rrPtr_q,   rrPtr_d;
  logic [IDX_W-1:0]   grant_q,   grant_d;
  logic               wrValid_q, wrValid_d;
  logic [ADDR_W-1:0]  wrAddr_q,  wrAddr_d;
  logic [DATA_W-1:0]  wrData_q,  wrData_d;

  logic [NUM_VEC-1:0] eligible;
  logic               grantFound;
  logic [IDX_W-1:0]   grantIdx;
  logic [IDX_W:0]     scanIdx;
  logic               handshake;
  logic [NUM_VEC-1:0] pbaClr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        tblAddr_q[i] <= '0;
        tblData_q[i] <= '0;
      end
      vecMask_q <= '1;
    end else if (tbl_we_i) begin
      tblAddr_q[tbl_idx_i] <= tbl_addr_i;
      tblData_q[tbl_idx_i] <= tbl_data_i;
      vecMask_q[tbl_idx_i] <= tbl_mask_i;
    end
  end

  // Scan downwards so the eligible vector closest to the rr pointer wins last.
  always_comb begin
    eligible   = pba_q & ~vecMask_q & {NUM_VEC{~func_mask_i}};
    grantFound = 1'b0;
    grantIdx   = '0;
    scanIdx    = '0;
    for (int k = NUM_VEC - 1; k >= 0; k--) begin
      scanIdx = {1'b0, rrPtr_q} + (IDX_W + 1)'(k);
      if (scanIdx >= (IDX_W + 1)'(NUM_VEC)) begin
        scanIdx = scanIdx - (IDX_W + 1)'(NUM_VEC);
      end
      if (eligible[scanIdx[IDX_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = scanIdx[IDX_W-1:0];
      end
    end
  end

  // A request arriving in the handshake cycle re-sets the bit being cleared.
  always_comb begin
    handshake = (state_q == SEND) && wrValid_q && wr.wr_ready;
    pbaClr    = handshake ? (NUM_VEC'(1) << grant_q) : '0;
    pba_d     = (pba_q & ~pbaClr) | intr_req_i;

    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    wrValid_d = wrValid_q;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;

    case (state_q)
      IDLE: begin
        if (grantFound) begin
          state_d   = SEND;
          grant_d   = grantIdx;
          wrValid_d = 1'b1;
          wrAddr_d  = tblAddr_q[grantIdx];
          wrData_d  = tblData_q[grantIdx];
          rrPtr_d   = (grantIdx == IDX_W'(NUM_VEC - 1)) ? '0 : grantIdx + IDX_W'(1);
        end
      end
      SEND: begin
        if (handshake) begin
          state_d   = IDLE;
          wrValid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pba_q     <= '0;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      wrValid_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
    end else begin
      state_q   <= state_d;
      pba_q     <= pba_d;
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      wrValid_q <= wrValid_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
    end
  end

  assign wr.wr_valid = wrValid_q;
  assign wr.wr_addr  = wrAddr_q;
  assign wr.wr_data  = wrData_q;
  assign pba_o       = pba_q;
  assign busy_o      = (state_q == SEND);

endmodule

// File: tb/tb_msix_wr_gen.sv
// Randomised scoreboard bench for msix_wr_gen against a transaction-level
// model of pending bits, masks and round-robin message selection.
module tb_msix_wr_gen;
  localparam int NUM_VEC = 8;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 3;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               tblWe;
  logic [IDX_W-1:0]   tblIdx;
  logic [ADDR_W-1:0]  tblAddr;
  logic [DATA_W-1:0]  tblData;
  logic               tblMask;
  logic               funcMask;
  logic [NUM_VEC-1:0] intrReq;
  logic [NUM_VEC-1:0] pba;
  logic               busy;

  msix_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wrIf ();

  msix_wr_gen #(.NUM_VEC(NUM_VEC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .tbl_we_i   (tblWe),
    .tbl_idx_i  (tblIdx),
    .tbl_addr_i (tblAddr),
    .tbl_data_i (tblData),
    .tbl_mask_i (tblMask),
    .func_mask_i(funcMask),
    .intr_req_i (intrReq),
    .wr         (wrIf),
    .pba_o      (pba),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  bit monEn   = 1'b0;

  // Reference state: what software would believe about the vectors.
  bit [NUM_VEC-1:0]  mPend;
  bit [NUM_VEC-1:0]  mMask;
  logic [ADDR_W-1:0] mAddr [NUM_VEC];
  logic [DATA_W-1:0] mData [NUM_VEC];
  int                mInFlight;
  int                mRr;
  exp_t              expQ[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit hs;
    bit [NUM_VEC-1:0] nextPend;
    int v;
    if (rst) begin
      mPend     = '0;
      mMask     = '1;
      mInFlight = -1;
      mRr       = 0;
      for (int i = 0; i < NUM_VEC; i++) begin
        mAddr[i] = '0;
        mData[i] = '0;
      end
    end else begin
      hs       = (mInFlight >= 0) && (wrIf.wr_ready === 1'b1);
      nextPend = mPend;
      if (hs) nextPend[mInFlight] = 1'b0;
      nextPend = nextPend | intrReq;
      if (mInFlight < 0) begin
        for (int k = 0; k < NUM_VEC; k++) begin
          v = (mRr + k) % NUM_VEC;
          if (mPend[v] && !mMask[v] && !funcMask) begin
            expQ.push_back('{addr: mAddr[v], data: mData[v]});
            mInFlight = v;
            mRr       = (v + 1) % NUM_VEC;
            break;
          end
        end
      end else if (hs) begin
        mInFlight = -1;
      end
      if (tblWe) begin
        mAddr[tblIdx] = tblAddr;
        mData[tblIdx] = tblData;
        mMask[tblIdx] = tblMask;
      end
      mPend = nextPend;
    end
  end

  // Monitor: a rising wr_valid pops the next expected message.
  always @(negedge clk) begin : monitor
    static bit   prevValid = 1'b0;
    static exp_t cur       = '{addr: '0, data: '0};
    if (monEn) begin
      checkOutput("wr_valid", 64'(wrIf.wr_valid), 64'(mInFlight >= 0));
      checkOutput("busy", 64'(busy), 64'(mInFlight >= 0));
      checkOutput("pba", 64'(pba), 64'(mPend));
      if (wrIf.wr_valid === 1'b1) begin
        if (!prevValid) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected none", wrIf.wr_addr, wrIf.wr_data);
          end else begin
            cur = expQ.pop_front();
          end
        end
        checkOutput("wr_addr", wrIf.wr_addr, cur.addr);
        checkOutput("wr_data", 64'(wrIf.wr_data), 64'(cur.data));
      end
      prevValid = (wrIf.wr_valid === 1'b1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeTbl(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic m);
    tblWe   = 1'b1;
    tblIdx  = IDX_W'(idx);
    tblAddr = a;
    tblData = d;
    tblMask = m;
    @(negedge clk);
    tblWe   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NUM_VEC-1:0] req);
    intrReq = req;
    @(negedge clk);
    intrReq = '0;
  endtask

  initial begin
    rst = 1'b1; tblWe = 1'b0; tblIdx = '0; tblAddr = '0; tblData = '0;
    tblMask = 1'b0; funcMask = 1'b0; intrReq = '0; wrIf.wr_ready = 1'b0;
    @(negedge clk);
    monEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // basic single message
    wrIf.wr_ready = 1'b1;
    writeTbl(0, 64'h1, 32'h1234_5678, 1'b0);
    applyStimulus(8'h01);
    cycles(5);

    // masked vector stays pending until unmasked
    writeTbl(3, 64'h3000, 32'h0000_0333, 1'b1);
    applyStimulus(8'h08);
    cycles(4);
    writeTbl(3, 64'h3000, 32'h0000_0333, 1'b0);
    cycles(4);

    // round-robin order and wrap
    writeTbl(1, 64'h1000, 32'h0000_0111, 1'b0);
    writeTbl(2, 64'h2000, 32'h0000_0222, 1'b0);
    writeTbl(5, 64'h5000, 32'h0000_0555, 1'b0);
    applyStimulus(8'h26);
    cycles(8);
    applyStimulus(8'h22);
    cycles(8);

    // backpressure, table rewrite and function mask during SEND
    wrIf.wr_ready = 1'b0;
    writeTbl(4, 64'h4000_0000_0000_0004, 32'h0000_0444, 1'b0);
    applyStimulus(8'h10);
    cycles(3);
    writeTbl(4, 64'h4000_0000_0000_0004, 32'h0000_DEAD, 1'b0);
    cycles(3);
    funcMask = 1'b1;
    cycles(4);
    wrIf.wr_ready = 1'b1;
    cycles(2);
    funcMask = 1'b0;
    cycles(4);

    // request on vec2 in its own handshake cycle
    wrIf.wr_ready = 1'b0;
    applyStimulus(8'h04);
    cycles(3);
    intrReq = 8'h04;
    wrIf.wr_ready = 1'b1;
    @(negedge clk);
    intrReq = '0;
    cycles(6);

    // reset while a write is outstanding
    wrIf.wr_ready = 1'b0;
    applyStimulus(8'h01);
    cycles(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hFF);
    cycles(6);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      intrReq = NUM_VEC'($urandom & $urandom & $urandom);
      wrIf.wr_ready = ($urandom % 4) != 0;
      if ($urandom % 50 == 0) funcMask = ~funcMask;
      rst = ($urandom % 300 == 0);
      tblWe = ($urandom % 10 == 0);
      if (tblWe) begin
        tblIdx  = IDX_W'($urandom % NUM_VEC);
        tblAddr = {$urandom, $urandom};
        tblData = $urandom;
        tblMask = ($urandom % 4 == 0);
      end
      @(negedge clk);
    end
    rst = 1'b0; tblWe = 1'b0; intrReq = '0; funcMask = 1'b0; wrIf.wr_ready = 1'b1;
    cycles(60);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
